vga_timing_core: RTL and testbench

- Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync generator used by the Tiny Tapeout VGA tops.
- Generalised in four ways:
  - every porch, sync and active length is a parameter;
  - sync polarity is selectable;
  - an internal pixel-clock-enable divider lets the system clock run faster than the pixel clock;
  - it emits single-cycle line, frame and vblank strobes plus a frame counter.
- Animation logic runs on `clk` using these strobes instead of being clocked from vsync.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/pix_tick_div.sv | 55 +++++
 rtl/vga_timing_core.sv | 154 +++++++++++++++
 tb/tb_vga_timing_core.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA raster generator.
//   vga_timing_t    : one complete raster description (lengths + sync polarity)
//   VGA_640X480_60  : 25.175 MHz industry timing, negative syncs
//   VGA_800X600_60  : 40 MHz industry timing, positive syncs
//   timing_total()  : sum of the four segment lengths of one axis
//   cnt_width()     : counter width needed to hold 0..n-1 (never less than 1)
package vga_timing_pkg;

    typedef struct packed {
        int h_display;
        int h_front;
        int h_sync;
        int h_back;
        int v_display;
        int v_front;
        int v_sync;
        int v_back;
        bit h_sync_pol;
        bit v_sync_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h_display: 640, h_front: 16, h_sync: 96,  h_back: 48,
        v_display: 480, v_front: 10, v_sync: 2,   v_back: 33,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0
    };

    localparam vga_timing_t VGA_800X600_60 = '{
        h_display: 800, h_front: 40, h_sync: 128, h_back: 88,
        v_display: 600, v_front: 1,  v_sync: 4,   v_back: 23,
        h_sync_pol: 1'b1, v_sync_pol: 1'b1
    };

    function automatic int timing_total(input int display, input int front,
                                        input int sync, input int back);
        return display + front + sync + back;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-clock-enable divider.
//   clk      : system clock
//   reset    : synchronous, active-high
//   pix_tick : high on the last clk of every CLK_DIV-clk pixel period
//   running  : low on reset and for the clk edge that leaves reset; the top
//              uses it to recognise the first post-reset cycle
// The count restarts at 0 on the first clk after reset so that the first
// pixel period is always a full CLK_DIV clks long.
module pix_tick_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick,
    output logic running
);

    localparam int                 DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pix_tick_div: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick_q, pix_tick_d;
    logic             running_q, running_d;

    always_comb begin
        div_d      = '0;
        running_d  = 1'b1;
        if (running_q && (div_q != DIV_LAST)) begin
            div_d = div_q + DIV_W'(1);
        end
        pix_tick_d = (div_d == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            pix_tick_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            div_q      <= div_d;
            pix_tick_q <= pix_tick_d;
            running_q  <= running_d;
        end
    end

    assign pix_tick = pix_tick_q;
    assign running  = running_q;

endmodule

// File: rtl/vga_timing_core.sv
// Parametrised VGA raster timing generator.
//   clk, reset          : system clock, synchronous active-high reset
//   hsync, vsync        : syncs at H_SYNC_POL / V_SYNC_POL active level
//   display_on          : inside the active picture area
//   hpos, vpos          : current pixel column / line
//   pix_tick            : last clk of the current pixel period
//   line_start          : first clk of hpos==0
//   frame_start         : first clk of (0,0)
//   vblank_start        : first clk of (0,V_DISPLAY)
//   frame_cnt           : completed frames, wraps modulo 2^FCNT_W
// Every output is a flop loaded from the decode of the next position, so
// syncs, display_on and strobes always describe the hpos/vpos shown in the
// same cycle.
module vga_timing_core
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = VGA_640X480_60.h_display,
    parameter int H_FRONT    = VGA_640X480_60.h_front,
    parameter int H_SYNC     = VGA_640X480_60.h_sync,
    parameter int H_BACK     = VGA_640X480_60.h_back,
    parameter int V_DISPLAY  = VGA_640X480_60.v_display,
    parameter int V_FRONT    = VGA_640X480_60.v_front,
    parameter int V_SYNC     = VGA_640X480_60.v_sync,
    parameter int V_BACK     = VGA_640X480_60.v_back,
    parameter bit H_SYNC_POL = VGA_640X480_60.h_sync_pol,
    parameter bit V_SYNC_POL = VGA_640X480_60.v_sync_pol,
    parameter int CLK_DIV    = 1,
    parameter int POS_W      = 10,
    parameter int FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              hsync,
    output logic              vsync,
    output logic              display_on,
    output logic [POS_W-1:0]  hpos,
    output logic [POS_W-1:0]  vpos,
    output logic              pix_tick,
    output logic              line_start,
    output logic              frame_start,
    output logic              vblank_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int H_TOTAL = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_len
        $error("vga_timing_core: every porch, sync and display length must be at least 1");
    end
    if (H_TOTAL > (1 << POS_W) || V_TOTAL > (1 << POS_W)) begin : g_bad_pos_w
        $error("vga_timing_core: POS_W too narrow for H_TOTAL/V_TOTAL");
    end

    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_DISP   = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_DISP   = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] HS_BEGIN = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] HS_END   = POS_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [POS_W-1:0] VS_BEGIN = POS_W'(V_DISPLAY + V_FRONT);
    localparam logic [POS_W-1:0] VS_END   = POS_W'(V_DISPLAY + V_FRONT + V_SYNC);

    logic advance;
    logic running;

    // advance is the registered pix_tick: the cycle being shown is the last
    // of its pixel, so the position moves on at this edge.
    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_div (
        .clk      (clk),
        .reset    (reset),
        .pix_tick (advance),
        .running  (running)
    );

    logic [POS_W-1:0]  hpos_q, hpos_d;
    logic [POS_W-1:0]  vpos_q, vpos_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              display_on_q, display_on_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic              vblank_start_q, vblank_start_d;

    always_comb begin
        hpos_d      = hpos_q;
        vpos_d      = vpos_q;
        frame_cnt_d = frame_cnt_q;

        if (advance) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                if (vpos_q == V_LAST) begin
                    vpos_d      = '0;
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                end else begin
                    vpos_d = vpos_q + POS_W'(1);
                end
            end else begin
                hpos_d = hpos_q + POS_W'(1);
            end
        end

        hsync_d      = ((hpos_d >= HS_BEGIN) && (hpos_d < HS_END)) ? H_SYNC_POL : !H_SYNC_POL;
        vsync_d      = ((vpos_d >= VS_BEGIN) && (vpos_d < VS_END)) ? V_SYNC_POL : !V_SYNC_POL;
        display_on_d = (hpos_d < H_DISP) && (vpos_d < V_DISP);

        // A strobe fires when a new position span begins: either the position
        // just moved, or this is the first clk out of reset showing (0,0).
        line_start_d   = (advance || !running) && (hpos_d == '0);
        frame_start_d  = line_start_d && (vpos_d == '0);
        vblank_start_d = line_start_d && (vpos_d == V_DISP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q         <= '0;
            vpos_q         <= '0;
            frame_cnt_q    <= '0;
            hsync_q        <= !H_SYNC_POL;
            vsync_q        <= !V_SYNC_POL;
            display_on_q   <= 1'b0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hpos_q         <= hpos_d;
            vpos_q         <= vpos_d;
            frame_cnt_q    <= frame_cnt_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            display_on_q   <= display_on_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign hpos         = hpos_q;
    assign vpos         = vpos_q;
    assign frame_cnt    = frame_cnt_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign display_on   = display_on_q;
    assign pix_tick     = advance;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Four differently configured instances run side by side on one clock and
// one reset.  Each cycle the expected outputs of every instance are computed
// from the cycle index since reset release (closed-form raster arithmetic),
// queued, and compared once the DUT has produced that cycle.
module tb_vga_timing_core;

    typedef struct packed {
        int hd, hf, hs, hb;
        int vd, vf, vs, vb;
        int div, fcw;
        bit hp, vp;
    } cfg_t;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        pt;
        logic        ls;
        logic        fs;
        logic        vb;
        logic [15:0] fc;
    } obs_t;

    localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 16, 1'b0, 1'b0};
    localparam cfg_t C1 = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 16, 1'b1, 1'b1};
    localparam cfg_t C2 = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 2, 1'b0, 1'b0};
    localparam cfg_t C3 = '{4, 1, 2, 1, 3, 1, 1, 1, 3, 16, 1'b1, 1'b1};

    function automatic cfg_t cfg_of(input int d);
        case (d)
            0:       return C0;
            1:       return C1;
            2:       return C2;
            default: return C3;
        endcase
    endfunction

    logic clk;
    logic reset;
    obs_t obs [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam cfg_t C = cfg_of(g);
        logic             hs, vs, de, pt, ls, fs, vb;
        logic [9:0]       h, v;
        logic [C.fcw-1:0] fc;

        vga_timing_core #(
            .H_DISPLAY (C.hd), .H_FRONT (C.hf), .H_SYNC (C.hs), .H_BACK (C.hb),
            .V_DISPLAY (C.vd), .V_FRONT (C.vf), .V_SYNC (C.vs), .V_BACK (C.vb),
            .H_SYNC_POL (C.hp), .V_SYNC_POL (C.vp),
            .CLK_DIV (C.div), .POS_W (10), .FCNT_W (C.fcw)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .hsync        (hs),
            .vsync        (vs),
            .display_on   (de),
            .hpos         (h),
            .vpos         (v),
            .pix_tick     (pt),
            .line_start   (ls),
            .frame_start  (fs),
            .vblank_start (vb),
            .frame_cnt    (fc)
        );

        assign obs[g] = {hs, vs, de, h, v, pt, ls, fs, vb, 16'(fc)};
    end

    function automatic obs_t model(input cfg_t c, input int k, input bit rst);
        obs_t o;
        int   ht, vt, p, sub, h, line, v, f;
        o = '0;
        if (rst) begin
            o.hsync = !c.hp;
            o.vsync = !c.vp;
            return o;
        end
        ht   = c.hd + c.hf + c.hs + c.hb;
        vt   = c.vd + c.vf + c.vs + c.vb;
        p    = k / c.div;
        sub  = k % c.div;
        h    = p % ht;
        line = p / ht;
        v    = line % vt;
        f    = line / vt;
        o.h     = 10'(h);
        o.v     = 10'(v);
        o.de    = (h < c.hd) && (v < c.vd);
        o.hsync = (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) ? c.hp : !c.hp;
        o.vsync = (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) ? c.vp : !c.vp;
        o.pt    = (sub == c.div - 1);
        o.ls    = (sub == 0) && (h == 0);
        o.fs    = o.ls && (v == 0);
        o.vb    = o.ls && (v == c.vd);
        o.fc    = 16'(f % (1 << c.fcw));
        return o;
    endfunction

    obs_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k     = 0;
    int   phase = 0;

    int   hs0_cnt = 0, hs0_first = -1, hs1_cnt = 0, c1_ls_k = -1;
    int   vb2_k = -1, vs3_cnt = 0, fs_n = 0;
    int   fs_k [6];
    int   fs_fc [6];

    task automatic check_int(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_obs(input int d, input int kk, input obs_t got, input obs_t exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL dut%0d k=%0d: got %h expected %h (hs,vs,de,h,v,pt,ls,fs,vb,fc)", d, kk, got, exp);
        end
    endtask

    task automatic record(input int kk);
        if (kk < 800 && obs[0].hsync == 1'b0) begin
            hs0_cnt++;
            if (hs0_first < 0) hs0_first = int'(obs[0].h);
        end
        if (kk < 1600 && obs[1].hsync == 1'b1) hs1_cnt++;
        if (obs[1].ls && kk > 0 && c1_ls_k < 0) c1_ls_k = kk;
        if (obs[2].vb && vb2_k < 0) vb2_k = kk;
        if (obs[2].fs && fs_n < 6) begin
            fs_k[fs_n]  = kk;
            fs_fc[fs_n] = int'(obs[2].fc);
            fs_n++;
        end
        if (kk < 144 && obs[3].vsync == 1'b1) vs3_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            bit   rst_now;
            int   kk;
            obs_t e;
            rst_now = reset;
            kk      = k;
            for (int d = 0; d < 4; d++) sb.push_back(model(cfg_of(d), kk, rst_now));
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                e = sb.pop_front();
                check_obs(d, kk, obs[d], e);
            end
            if (!rst_now && phase == 2) record(kk);
            k = rst_now ? 0 : k + 1;
        end
    endtask

    initial begin
        reset = 1'b1;
        phase = 1;
        run(3);
        reset = 1'b0;
        run(1101);
        // instance 0 now shows hpos=300, vpos=1; reset for one edge mid-frame
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        phase = 2;
        run(6000);

        check_int("hsync0_width", hs0_cnt, 96);
        check_int("hsync0_first_hpos", hs0_first, 656);
        check_int("hsync1_pos_width_div2", hs1_cnt, 192);
        check_int("line_start1_period", c1_ls_k, 1600);
        check_int("vblank2_clk", vb2_k, 24);
        check_int("vsync3_pos_clks", vs3_cnt, 24);
        check_int("frame_starts_seen", fs_n, 6);
        for (int i = 0; i < 6; i++) begin
            check_int($sformatf("frame_start2_clk%0d", i), fs_k[i], 48 * i);
            check_int($sformatf("frame_cnt2_at%0d", i), fs_fc[i], i % 4);
        end
        check_int("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
